alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_seq_fifo.sv | 59 +++++
 rtl/alu_op_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU operation sequencer: command payload and FSM states.
package alu_pkg;

   localparam int OPCODE_W  = 3;
   localparam int OPERAND_W = 4;

   typedef struct packed {
      logic [OPCODE_W-1:0]  opcode;
      logic [OPERAND_W-1:0] op1;
      logic [OPERAND_W-1:0] op2;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Command FIFO for the ALU sequencer; power-of-two depth, synchronous flush.
module alu_seq_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic flush,
   input  logic push,
   input  logic pop,
   input  cmd_t wr_data,
   output cmd_t rd_data,
   output logic full,
   output logic empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   cmd_t           mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands and issues them one at a time, waiting ALU_LAT cycles per op.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no op in flight; pops the FIFO head when one is queued
//   ST_ISSUE | operands just loaded; op_valid high for this single cycle
//   ST_WAIT  | counting down the ALU latency; op_done when count hits 0
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [OPCODE_W-1:0]  cmd_opcode,
   input  logic [OPERAND_W-1:0] cmd_op1,
   input  logic [OPERAND_W-1:0] cmd_op2,
   output logic [OPCODE_W-1:0]  OPCODE,
   output logic [OPERAND_W-1:0] OP1,
   output logic [OPERAND_W-1:0] OP2,
   output logic                 op_valid,
   output logic                 op_done,
   output logic                 busy,
   output logic [7:0]           issued_cnt
);

   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   seq_state_t state;
   seq_state_t state_nxt;
   logic [3:0] wait_cnt;
   logic [3:0] wait_cnt_nxt;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;
   logic       pop;
   cmd_t       head;
   cmd_t       cmd_in;

   assign cmd_ready = !fifo_full && !flush;
   assign push      = cmd_valid && cmd_ready;
   assign cmd_in    = '{opcode: cmd_opcode, op1: cmd_op1, op2: cmd_op2};
   assign busy      = (state != ST_IDLE) || !fifo_empty;

   alu_seq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush   (flush),
      .push    (push),
      .pop     (pop),
      .wr_data (cmd_in),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      pop          = 1'b0;
      op_valid     = 1'b0;
      op_done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && !flush) begin
               pop       = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            op_valid = 1'b1;
            if (flush) begin
               state_nxt    = ST_IDLE;
               wait_cnt_nxt = '0;
            end else begin
               state_nxt    = ST_WAIT;
               wait_cnt_nxt = LAT_M1;
            end
         end
         ST_WAIT: begin
            // A flush on the terminal cycle swallows the pending op_done.
            if (flush) begin
               state_nxt    = ST_IDLE;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == '0) begin
               op_done   = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               wait_cnt_nxt = wait_cnt - 1'b1;
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   // Operand registers change only on a pop, so they hold through flush.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         OPCODE <= '0;
         OP1    <= '0;
         OP2    <= '0;
      end else if (pop) begin
         OPCODE <= head.opcode;
         OP1    <= head.op1;
         OP2    <= head.op2;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) issued_cnt <= '0;
      else if (op_valid) issued_cnt <= issued_cnt + 1'b1;
   end

   a_valid_done_excl: assert property (@(posedge clk) disable iff (!rstn)
      !(op_valid && op_done));

   a_done_after_valid: assert property (@(posedge clk) disable iff (!rstn)
      op_done |-> $past(op_valid, ALU_LAT));

endmodule
